// File: rtl/mem_sram_pkg.sv
// Shared types and opcode constants for the mem_sram memory target.
package mem_sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic MEM_OP_RD = 1'b0;
    localparam logic MEM_OP_WR = 1'b1;

endpackage

// File: rtl/mem_rd_skid.sv
// Two-entry read-beat FIFO; head is presented as the read beat, popped on handshake.
module mem_rd_skid #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [1:0]   count
);

    logic [W-1:0] entry [2];
    logic         wr_sel;
    logic         rd_sel;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_sel] <= push_data;
                wr_sel        <= ~wr_sel;
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != 2'd0);
    assign data  = entry[rd_sel];

endmodule

// File: rtl/mem_sram.sv
// Word-addressed SRAM serving read/write bursts from the AXI-to-mem bridge's simple mem interface.
module mem_sram
    import mem_sram_pkg::*;
#(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 32,
    parameter int MEM_DATA_BITS = 64,
    parameter int DEPTH_BITS    = 10
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
    input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    input  logic                     mem_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    output logic                     mem_rd_valid,
    output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    input  logic                     mem_rd_ready,
    output logic                     busy,
    output logic                     err,
    output state_t                   fsm_state
);

    localparam int OFF_BITS = $clog2(MEM_DATA_BITS / 8);

    state_t                    state;
    logic [DEPTH_BITS-1:0]     ptr;
    logic [MEM_LEN_BITS-1:0]   beats_left;
    logic [MEM_LEN_BITS:0]     issue_left;
    logic [MEM_DATA_BITS-1:0]  sram [0:(1 << DEPTH_BITS) - 1];
    logic [MEM_DATA_BITS-1:0]  sram_q;
    logic [1:0]                fifo_count;
    logic                      fifo_valid;
    logic                      issue;
    logic                      rd_fire;
    logic                      wr_en;
    logic                      addr_high;

    // The SRAM read port lands directly in the skid entry, so its storage is the 1-cycle read latency.
    assign sram_q    = sram[ptr];
    assign issue     = (state == READ) && (issue_left != '0) && (fifo_count < 2'd2);
    assign rd_fire   = fifo_valid && mem_rd_ready;
    assign wr_en     = (state == WRITE) && mem_wr_valid;
    assign addr_high = (mem_req_addr >> (OFF_BITS + DEPTH_BITS)) != '0;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            sram[ptr] <= mem_wr_bits;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            beats_left <= '0;
            issue_left <= '0;
            err        <= 1'b0;
        end else begin
            if ((mem_req_valid && state != IDLE) || (mem_wr_valid && state != WRITE)) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mem_req_valid) begin
                        ptr        <= mem_req_addr[OFF_BITS +: DEPTH_BITS];
                        beats_left <= mem_req_len;
                        issue_left <= {1'b0, mem_req_len} + 1'b1;
                        if (addr_high) begin
                            err <= 1'b1;
                        end
                        state <= (mem_req_opcode == MEM_OP_WR) ? WRITE : READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        ptr        <= ptr + 1'b1;
                        issue_left <= issue_left - 1'b1;
                    end
                    if (rd_fire) begin
                        if (beats_left == '0) begin
                            state <= IDLE;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_wr_valid) begin
                        ptr <= ptr + 1'b1;
                        if (beats_left == '0) begin
                            state <= IDLE;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_rd_skid #(
        .W(MEM_DATA_BITS)
    ) u_rd_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (issue),
        .push_data (sram_q),
        .pop       (rd_fire),
        .valid     (fifo_valid),
        .data      (mem_rd_bits),
        .count     (fifo_count)
    );

    assign mem_rd_valid = fifo_valid;
    assign busy         = (state != IDLE);
    assign fsm_state    = state;

endmodule

// File: tb/tb_mem_sram.sv
// Randomized self-checking bench for mem_sram against a word-array reference model.
module tb_mem_sram;
    import mem_sram_pkg::*;

    localparam int DW = 64;
    localparam int LW = 8;
    localparam int AW = 32;
    localparam int DB = 10;
    localparam int NW = 1024;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem_req_valid = 1'b0;
    logic          mem_req_opcode = 1'b0;
    logic [LW-1:0] mem_req_len = '0;
    logic [AW-1:0] mem_req_addr = '0;
    logic          mem_wr_valid = 1'b0;
    logic [DW-1:0] mem_wr_bits = '0;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_bits;
    logic          mem_rd_ready = 1'b0;
    logic          busy;
    logic          err;
    state_t        fsm_state;

    always #5 clock = ~clock;

    mem_sram #(
        .MEM_LEN_BITS (LW),
        .MEM_ADDR_BITS(AW),
        .MEM_DATA_BITS(DW),
        .DEPTH_BITS   (DB)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .mem_req_valid (mem_req_valid),
        .mem_req_opcode(mem_req_opcode),
        .mem_req_len   (mem_req_len),
        .mem_req_addr  (mem_req_addr),
        .mem_wr_valid  (mem_wr_valid),
        .mem_wr_bits   (mem_wr_bits),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_bits   (mem_rd_bits),
        .mem_rd_ready  (mem_rd_ready),
        .busy          (busy),
        .err           (err),
        .fsm_state     (fsm_state)
    );

    logic [DW-1:0] model [NW];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] burst_d [256];
    logic [DW-1:0] got [256];
    int            checks = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [DW-1:0] got_v, input logic [DW-1:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got_v, exp_v);
        end
    endtask

    function automatic int widx(input logic [AW-1:0] addr, input int i);
        return (int'(addr >> 3) + i) % NW;
    endfunction

    task automatic apply_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        mem_req_valid = 1'b0;
        mem_wr_valid = 1'b0;
        mem_rd_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input int len, input bit gaps);
        @(posedge clock);
        #1;
        mem_req_valid  = 1'b1;
        mem_req_opcode = MEM_OP_WR;
        mem_req_len    = LW'(len);
        mem_req_addr   = addr;
        @(posedge clock);
        #1;
        mem_req_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    mem_wr_valid = 1'b0;
                    @(posedge clock);
                    #1;
                end
            end
            mem_wr_valid = 1'b1;
            mem_wr_bits  = burst_d[i];
            model[widx(addr, i)] = burst_d[i];
            @(posedge clock);
            #1;
        end
        mem_wr_valid = 1'b0;
        @(negedge clock);
        check("wr_busy_end", 64'(busy), 64'(0));
    endtask

    // mode 0: ready held high; 1: random ready; 2: fixed 1,0,0,1,0,1 ready pattern
    task automatic rd_burst(input logic [AW-1:0] addr, input int len, input int mode, input bit inject);
        int            k = 0;
        int            n = 0;
        int            budget;
        logic [5:0]    pat = 6'b101001;
        logic [DW-1:0] e;
        exp_q.delete();
        for (int i = 0; i <= len; i++) exp_q.push_back(model[widx(addr, i)]);
        budget = 8 * (len + 1) + 10;
        @(posedge clock);
        #1;
        mem_req_valid  = 1'b1;
        mem_req_opcode = MEM_OP_RD;
        mem_req_len    = LW'(len);
        mem_req_addr   = addr;
        mem_rd_ready   = 1'b0;
        @(negedge clock);
        check("rd_valid_req_cycle", 64'(mem_rd_valid), 64'(0));
        while (n <= len && k < budget) begin
            @(posedge clock);
            #1;
            k++;
            mem_req_valid  = inject && (k == 1);
            mem_req_opcode = MEM_OP_WR;
            case (mode)
                0:       mem_rd_ready = 1'b1;
                1:       mem_rd_ready = 1'($urandom_range(0, 1));
                default: mem_rd_ready = pat[k % 6];
            endcase
            @(negedge clock);
            if (mem_rd_valid && mem_rd_ready) begin
                if (exp_q.size() == 0) begin
                    check("rd_extra_beat", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rd_beat%0d", n), mem_rd_bits, e);
                    if (mode == 0) check("rd_latency", 64'(k), 64'(n + 2));
                    got[n] = mem_rd_bits;
                end
                n++;
            end
        end
        check("rd_all_beats", 64'(n), 64'(len + 1));
        @(posedge clock);
        #1;
        mem_req_valid = 1'b0;
        mem_rd_ready  = 1'b0;
        @(negedge clock);
        check("rd_busy_end", 64'(busy), 64'(0));
        check("rd_valid_end", 64'(mem_rd_valid), 64'(0));
    endtask

    initial begin
        int n;
        int k;
        logic [DW-1:0] junk;

        // reset state
        #2;
        check("rst_rd_valid", 64'(mem_rd_valid), 64'(0));
        check("rst_rd_bits", mem_rd_bits, 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_state", 64'(fsm_state), 64'(IDLE));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // fill the whole memory with known random contents using max-length bursts
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 256; i++) burst_d[i] = {$urandom, $urandom};
            wr_burst(AW'(b * 2048), 255, 1'b0);
        end

        // basic write then read
        burst_d[0] = 64'h11; burst_d[1] = 64'h22; burst_d[2] = 64'h33; burst_d[3] = 64'h44;
        wr_burst(32'h100, 3, 1'b1);
        rd_burst(32'h100, 3, 0, 1'b0);
        check("basic_d0", got[0], 64'h11);
        check("basic_d1", got[1], 64'h22);
        check("basic_d2", got[2], 64'h33);
        check("basic_d3", got[3], 64'h44);
        check("basic_err", 64'(err), 64'(0));

        // backpressure
        rd_burst(32'h100, 3, 2, 1'b0);
        check("bp_d0", got[0], 64'h11);
        check("bp_d3", got[3], 64'h44);

        // wrap at the top of the memory
        burst_d[0] = 64'hA; burst_d[1] = 64'hB;
        wr_burst(32'h1FF8, 1, 1'b0);
        rd_burst(32'h1FF8, 1, 0, 1'b0);
        check("wrap_d0", got[0], 64'hA);
        check("wrap_d1", got[1], 64'hB);
        rd_burst(32'h0, 0, 0, 1'b0);
        check("wrap_word0", got[0], 64'hB);

        // single beat
        burst_d[0] = 64'hDEAD;
        wr_burst(32'h0, 0, 1'b0);
        rd_burst(32'h0, 0, 0, 1'b0);
        check("single_d0", got[0], 64'hDEAD);

        // random traffic
        for (int t = 0; t < 24; t++) begin
            logic [AW-1:0] a;
            int            l;
            a = AW'($urandom_range(0, 16'h1FFF));
            l = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= l; i++) burst_d[i] = {$urandom, $urandom};
                wr_burst(a, l, 1'b1);
            end else begin
                rd_burst(a, l, 1, 1'b0);
            end
        end
        check("rand_err", 64'(err), 64'(0));

        // request while reading is ignored but flagged
        rd_burst(32'h100, 3, 0, 1'b1);
        check("req_in_read_err", 64'(err), 64'(1));
        check("req_in_read_d0", got[0], 64'h11);

        // reset in the middle of an 8-beat read
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(model[widx(32'h200, i)]);
        @(posedge clock);
        #1;
        mem_req_valid  = 1'b1;
        mem_req_opcode = MEM_OP_RD;
        mem_req_len    = LW'(7);
        mem_req_addr   = 32'h200;
        n = 0;
        k = 0;
        while (n < 2 && k < 20) begin
            @(posedge clock);
            #1;
            k++;
            mem_req_valid = 1'b0;
            mem_rd_ready  = 1'b1;
            @(negedge clock);
            if (mem_rd_valid && mem_rd_ready) begin
                check($sformatf("mid_beat%0d", n), mem_rd_bits, exp_q.pop_front());
                n++;
            end
        end
        check("mid_two_beats", 64'(n), 64'(2));
        mem_rd_ready = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(mem_rd_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_err", 64'(err), 64'(0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        rd_burst(32'h200, 7, 1, 1'b0);

        // write beat while idle is dropped
        junk = ~model[0];
        @(posedge clock);
        #1;
        mem_wr_valid = 1'b1;
        mem_wr_bits  = junk;
        @(posedge clock);
        #1;
        mem_wr_valid = 1'b0;
        @(negedge clock);
        check("idle_wr_err", 64'(err), 64'(1));
        rd_burst(32'h0, 0, 0, 1'b0);
        check("idle_wr_unchanged", got[0], 64'hDEAD);

        // out-of-range address flags err but uses the truncated pointer
        apply_reset();
        check("pre_range_err", 64'(err), 64'(0));
        rd_burst(32'h8000_0000, 0, 0, 1'b0);
        check("range_err", 64'(err), 64'(1));
        check("range_d0", got[0], 64'hDEAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
